mem_stage: RTL and testbench

- Memory-access stage directly downstream of the execute stage; consumes the EX/MEM pipeline fields: aluresult, writedata, pcplus4, rd, regwrite, resultsrc, memwrite.
- Drives a valid/ready data-memory bus for word loads and stores, and raises stall_m to the hazard unit while an access is outstanding.
- Owns the MEM/WB pipeline register, so every wb_* output is registered.

---
 rtl/mem_stage.sv | 147 ++++++++++++++
 tb/tb_mem_stage.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ------------------------------------------------------------------------
// mem_stage : memory-access stage, valid/ready dmem bus + MEM/WB register
// Revision  : 1.0
// ------------------------------------------------------------------------
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_m,
  input  logic [31:0] aluresult,
  input  logic [31:0] writedata,
  input  logic [31:0] pcplus4,
  input  logic [4:0]  rd,
  input  logic        regwrite,
  input  logic [1:0]  resultsrc,
  input  logic        memwrite,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_err,
  output logic        stall_m,
  output logic        wb_valid,
  output logic [31:0] wb_aluresult,
  output logic [31:0] wb_readdata,
  output logic [31:0] wb_pcplus4,
  output logic [4:0]  wb_rd,
  output logic        wb_regwrite,
  output logic [1:0]  wb_resultsrc,
  output logic        exc_misaligned,
  output logic        exc_bus,
  output logic [31:0] exc_addr
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_req  = 2'd1;
  localparam logic [1:0] c_st_resp = 2'd2;
  localparam logic [9:0] c_timeout = TIMEOUT_CYCLES[9:0];

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic [9:0] r_cnt;
  logic [9:0] w_cnt_inc;
  logic       w_memop;
  logic       w_misal;
  logic       w_amemop;
  logic       w_is_load;
  logic       w_in_resp;
  logic       w_rsp_done;
  logic       w_timeout;
  logic       w_done;
  logic       w_buserr;

  assign w_memop    = valid_m & (memwrite | (resultsrc == 2'b01));
  assign w_misal    = w_memop & (aluresult[1:0] != 2'b00);
  assign w_amemop   = w_memop & ~w_misal;
  assign w_is_load  = (resultsrc == 2'b01) & ~memwrite;
  assign w_in_resp  = (r_state == c_st_resp);
  assign w_cnt_inc  = r_cnt + 10'd1;
  assign w_rsp_done = w_in_resp & dmem_rvalid;
  // Timeout completes in the cycle whose increment would reach the limit.
  assign w_timeout  = w_in_resp & ~dmem_rvalid & (w_cnt_inc == c_timeout);
  assign w_done     = w_rsp_done | w_timeout;
  assign w_buserr   = (w_rsp_done & dmem_err) | w_timeout;

  assign dmem_we    = memwrite;
  assign dmem_addr  = {aluresult[31:2], 2'b00};
  assign dmem_wdata = writedata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: if (w_amemop) w_state_next = dmem_gnt ? c_st_resp : c_st_req;
      c_st_req:  if (dmem_gnt) w_state_next = c_st_resp;
      c_st_resp: if (w_done)   w_state_next = c_st_idle;
      default:   w_state_next = c_st_idle;
    endcase
  end

  // Gated by rst_n so the bus request and stall drop the moment reset asserts.
  always_comb begin
    dmem_req = 1'b0;
    stall_m  = 1'b0;
    if (rst_n && w_amemop) begin
      dmem_req = ~w_in_resp;
      stall_m  = ~w_done;
    end
  end

  // Counter is held at zero outside RESP, so it is clear on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!w_in_resp) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid       <= 1'b0;
      wb_aluresult   <= '0;
      wb_readdata    <= '0;
      wb_pcplus4     <= '0;
      wb_rd          <= '0;
      wb_regwrite    <= 1'b0;
      wb_resultsrc   <= '0;
      exc_misaligned <= 1'b0;
      exc_bus        <= 1'b0;
      exc_addr       <= '0;
    end else if (stall_m) begin
      wb_valid       <= 1'b0;
      wb_regwrite    <= 1'b0;
      exc_misaligned <= 1'b0;
      exc_bus        <= 1'b0;
      exc_addr       <= '0;
    end else begin
      wb_valid       <= valid_m;
      wb_aluresult   <= aluresult;
      wb_readdata    <= (w_rsp_done && w_is_load) ? dmem_rdata : 32'h0;
      wb_pcplus4     <= pcplus4;
      wb_rd          <= rd;
      wb_regwrite    <= valid_m & regwrite & ~w_misal & ~w_buserr;
      wb_resultsrc   <= resultsrc;
      exc_misaligned <= w_misal;
      exc_bus        <= w_buserr;
      exc_addr       <= (w_misal || w_buserr) ? aluresult : 32'h0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// tb_mem_stage : scoreboard bench for mem_stage (TIMEOUT_CYCLES = 4)
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_m, regwrite, memwrite;
  logic [31:0] aluresult, writedata, pcplus4;
  logic [4:0]  rd;
  logic [1:0]  resultsrc;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid, dmem_err;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall_m, wb_valid, wb_regwrite, exc_misaligned, exc_bus;
  logic [31:0] wb_aluresult, wb_readdata, wb_pcplus4, exc_addr;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_resultsrc;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .valid_m(valid_m), .aluresult(aluresult),
    .writedata(writedata), .pcplus4(pcplus4), .rd(rd), .regwrite(regwrite),
    .resultsrc(resultsrc), .memwrite(memwrite), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .dmem_err(dmem_err), .stall_m(stall_m), .wb_valid(wb_valid),
    .wb_aluresult(wb_aluresult), .wb_readdata(wb_readdata),
    .wb_pcplus4(wb_pcplus4), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .wb_resultsrc(wb_resultsrc), .exc_misaligned(exc_misaligned),
    .exc_bus(exc_bus), .exc_addr(exc_addr)
  );

  typedef struct packed {
    logic [31:0] aluresult;
    logic [31:0] readdata;
    logic [31:0] pcplus4;
    logic [4:0]  rd;
    logic        regwrite;
    logic [1:0]  resultsrc;
    logic        exc_mis;
    logic        exc_bus;
    logic [31:0] exc_addr;
  } wb_t;

  wb_t exp_q[$];
  int  total = 0;
  int  bad = 0;

  // Scoreboard: every valid MEM/WB slot must match the oldest expectation.
  always @(negedge clk) begin : sb_monitor
    wb_t e_obs, e_exp;
    total++;
    if (wb_valid === 1'b1) begin
      e_obs = {wb_aluresult, wb_readdata, wb_pcplus4, wb_rd, wb_regwrite,
               wb_resultsrc, exc_misaligned, exc_bus, exc_addr};
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: got slot %h, required no writeback", e_obs);
      end else begin
        e_exp = exp_q.pop_front();
        if (e_obs !== e_exp) begin
          bad++;
          $display("FAIL wb_fields: got %h, required %h", e_obs, e_exp);
        end
      end
    end else if ({wb_valid, wb_regwrite, exc_misaligned, exc_bus, exc_addr} !== 36'h0) begin
      bad++;
      $display("FAIL wb_bubble: got v=%b rw=%b mis=%b bus=%b addr=%h, required all 0",
               wb_valid, wb_regwrite, exc_misaligned, exc_bus, exc_addr);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc,
                          input logic [4:0] r, input logic rw, input logic [1:0] rs, input logic mw);
    valid_m = 1'b1; aluresult = a; writedata = wd; pcplus4 = pc;
    rd = r; regwrite = rw; resultsrc = rs; memwrite = mw;
  endtask

  task automatic drive_bubble;
    valid_m = 1'b0; aluresult = '0; writedata = '0; pcplus4 = '0;
    rd = '0; regwrite = 1'b0; resultsrc = 2'b00; memwrite = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] rdat, input logic [31:0] pc,
                          input logic [4:0] r, input logic rw, input logic [1:0] rs,
                          input logic mis, input logic bus, input logic [31:0] ea);
    wb_t e;
    e = {a, rdat, pc, r, rw, rs, mis, bus, ea};
    exp_q.push_back(e);
  endtask

  // Plays the bus side of one access; gnt_at/rv_at are cycle indices (-1 = never).
  task automatic run_mem(input logic [31:0] ea, input logic [31:0] ewd, input logic ewe,
                         input int gnt_at, input int rv_at, input logic err,
                         input logic [31:0] rdat, output int req_n, output int stall_n,
                         output bit ok, output bit done);
    req_n = 0; stall_n = 0; ok = 1'b1; done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      dmem_gnt    = (k == gnt_at);
      dmem_rvalid = (k == rv_at);
      dmem_err    = (k == rv_at) && err;
      dmem_rdata  = (k == rv_at) ? rdat : 32'h0;
      #1;
      if (dmem_req === 1'b1) begin
        req_n++;
        if (dmem_addr !== ea || dmem_we !== ewe || dmem_wdata !== ewd) ok = 1'b0;
      end
      if (stall_m === 1'b1) stall_n++;
      else done = 1'b1;
      tick();
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_err = 1'b0; dmem_rdata = '0;
    end
  endtask

  task automatic test_reset;
    drive_op(32'h40, 32'h0, 32'h44, 5'd1, 1'b1, 2'b01, 1'b0);
    #7;
    total++;
    if (dmem_req !== 1'b0 || stall_m !== 1'b0) begin
      bad++; $display("FAIL reset_bus: got req=%b stall=%b, required 0 0", dmem_req, stall_m);
    end
    total++;
    if ({wb_valid, wb_regwrite, wb_aluresult, wb_readdata, wb_rd} !== 71'h0) begin
      bad++; $display("FAIL reset_wb: got v=%b rw=%b alu=%h rd=%h, required all 0",
                      wb_valid, wb_regwrite, wb_aluresult, wb_readdata);
    end
    drive_bubble();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add;
    drive_op(32'h1234, 32'h0, 32'h1238, 5'd5, 1'b1, 2'b00, 1'b0);
    push_exp(32'h1234, 32'h0, 32'h1238, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
    #1;
    total++;
    if (stall_m !== 1'b0 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL add_nostall: got stall=%b req=%b, required 0 0", stall_m, dmem_req);
    end
    tick();
    drive_bubble();
    tick(); tick();
  endtask

  task automatic test_load;
    int rq, st; bit ok, dn;
    drive_op(32'h100, 32'h0, 32'h104, 5'd7, 1'b1, 2'b01, 1'b0);
    push_exp(32'h100, 32'hDEADBEEF, 32'h104, 5'd7, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0);
    run_mem(32'h100, 32'h0, 1'b0, 0, 1, 1'b0, 32'hDEADBEEF, rq, st, ok, dn);
    drive_bubble();
    total++;
    if (!dn || rq != 1 || st != 1 || !ok) begin
      bad++; $display("FAIL load_min: got done=%b req=%0d stall=%0d bus_ok=%b, required 1 1 1 1", dn, rq, st, ok);
    end
    tick(); tick();
  endtask

  task automatic test_store;
    int rq, st; bit ok, dn;
    drive_op(32'h200, 32'hA5A5A5A5, 32'h204, 5'd0, 1'b0, 2'b00, 1'b1);
    push_exp(32'h200, 32'h0, 32'h204, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
    run_mem(32'h200, 32'hA5A5A5A5, 1'b1, 3, 6, 1'b0, 32'h0, rq, st, ok, dn);
    drive_bubble();
    total++;
    if (!dn || rq != 4 || st != 6 || !ok) begin
      bad++; $display("FAIL store_wait: got done=%b req=%0d stall=%0d bus_ok=%b, required 1 4 6 1", dn, rq, st, ok);
    end
    tick(); tick();
  endtask

  task automatic test_misaligned;
    drive_op(32'h103, 32'h0, 32'h108, 5'd9, 1'b1, 2'b01, 1'b0);
    push_exp(32'h103, 32'h0, 32'h108, 5'd9, 1'b0, 2'b01, 1'b1, 1'b0, 32'h103);
    #1;
    total++;
    if (dmem_req !== 1'b0 || stall_m !== 1'b0) begin
      bad++; $display("FAIL misal_nobus: got req=%b stall=%b, required 0 0", dmem_req, stall_m);
    end
    tick();
    drive_bubble();
    tick(); tick();
  endtask

  task automatic test_timeout;
    int rq, st; bit ok, dn;
    drive_op(32'h300, 32'h0, 32'h30C, 5'd3, 1'b1, 2'b01, 1'b0);
    push_exp(32'h300, 32'h0, 32'h30C, 5'd3, 1'b0, 2'b01, 1'b0, 1'b1, 32'h300);
    run_mem(32'h300, 32'h0, 1'b0, 0, -1, 1'b0, 32'h0, rq, st, ok, dn);
    drive_bubble();
    total++;
    if (!dn || rq != 1 || st != TO) begin
      bad++; $display("FAIL timeout_len: got done=%b req=%0d stall=%0d, required 1 1 %0d", dn, rq, st, TO);
    end
    tick();
    dmem_rvalid = 1'b1; dmem_err = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    #1;
    total++;
    if (stall_m !== 1'b0 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL stray_bus: got stall=%b req=%b, required 0 0", stall_m, dmem_req);
    end
    tick();
    dmem_rvalid = 1'b0; dmem_err = 1'b0; dmem_rdata = '0;
    total++;
    if (wb_valid !== 1'b0 || exc_bus !== 1'b0) begin
      bad++; $display("FAIL stray_rvalid: got wb_valid=%b exc_bus=%b, required 0 0", wb_valid, exc_bus);
    end
    tick();
  endtask

  task automatic test_bus_err;
    int rq, st; bit ok, dn;
    drive_op(32'h400, 32'h0, 32'h404, 5'd4, 1'b1, 2'b01, 1'b0);
    push_exp(32'h400, 32'h55, 32'h404, 5'd4, 1'b0, 2'b01, 1'b0, 1'b1, 32'h400);
    run_mem(32'h400, 32'h0, 1'b0, 0, 1, 1'b1, 32'h55, rq, st, ok, dn);
    drive_bubble();
    total++;
    if (!dn || st != 1) begin
      bad++; $display("FAIL err_len: got done=%b stall=%0d, required 1 1", dn, st);
    end
    tick(); tick();
  endtask

  task automatic test_back_to_back;
    int rq, st; bit ok, dn;
    drive_op(32'h10, 32'h0, 32'h14, 5'd10, 1'b1, 2'b00, 1'b0);
    push_exp(32'h10, 32'h0, 32'h14, 5'd10, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
    tick();
    drive_op(32'h20, 32'h0, 32'h18, 5'd11, 1'b1, 2'b01, 1'b0);
    push_exp(32'h20, 32'h11223344, 32'h18, 5'd11, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0);
    run_mem(32'h20, 32'h0, 1'b0, 0, 1, 1'b0, 32'h11223344, rq, st, ok, dn);
    drive_op(32'h30, 32'h0, 32'h1C, 5'd12, 1'b1, 2'b00, 1'b0);
    push_exp(32'h30, 32'h0, 32'h1C, 5'd12, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
    #1;
    total++;
    if (!dn || st != 1 || stall_m !== 1'b0) begin
      bad++; $display("FAIL b2b_flow: got done=%b stall_cnt=%0d stall=%b, required 1 1 0", dn, st, stall_m);
    end
    tick();
    drive_bubble();
    tick(); tick();
  endtask

  task automatic test_reset_mid;
    drive_op(32'h500, 32'h0, 32'h504, 5'd2, 1'b1, 2'b01, 1'b0);
    dmem_gnt = 1'b0;
    tick();
    total++;
    if (dmem_req !== 1'b1 || stall_m !== 1'b1) begin
      bad++; $display("FAIL req_hold: got req=%b stall=%b, required 1 1", dmem_req, stall_m);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (dmem_req !== 1'b0 || stall_m !== 1'b0 || wb_valid !== 1'b0) begin
      bad++; $display("FAIL rst_async: got req=%b stall=%b wb_valid=%b, required 0 0 0",
                      dmem_req, stall_m, wb_valid);
    end
    drive_op(32'h600, 32'h0, 32'h604, 5'd6, 1'b1, 2'b00, 1'b0);
    tick();
    rst_n = 1'b1;
    push_exp(32'h600, 32'h0, 32'h604, 5'd6, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
    #1;
    total++;
    if (stall_m !== 1'b0 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL post_rst_add: got stall=%b req=%b, required 0 0", stall_m, dmem_req);
    end
    tick();
    drive_bubble();
    tick(); tick();
  endtask

  initial begin
    drive_bubble();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_err = 1'b0; dmem_rdata = '0;
    test_reset();
    test_add();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_bus_err();
    test_back_to_back();
    test_reset_mid();
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
